// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   uart_state_t    : serializer FSM states (PARITY is only entered when the
//                     UART_TX_PARITY_EN build macro is defined)
//   UART_DATA_BITS  : payload bits per frame
//   UART_IDLE_LEVEL : line level while idle and during the stop bit
package uart_pkg;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART serializer.
//   clk, reset : system clock, asynchronous active-high reset
//   push/wdata : write request; ignored when full
//   pop/rdata  : read request; rdata always shows the head entry
//   full/empty : occupancy flags
//   level      : occupancy, one bit wider than the pointers
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full;   // full is judged before any same-cycle pop
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: buffers CPU bytes and sends them as async frames
// (start, 8 data bits LSB first, [even parity], stop).
//   clk, reset : system clock, asynchronous active-high reset
//   tx_data    : byte from CPU, sampled on every edge with tx_valid=1
//   tx_valid   : write strobe, no backpressure
//   tx_out     : serial line, idle high
//   busy       : frame in progress or bytes queued
//   overflow   : sticky, a byte was dropped on a full FIFO
//   fifo_level : current FIFO occupancy
// Build macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  parameter  int FIFO_DEPTH   = 4,
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT),
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_out,
  output logic             busy,
  output logic             overflow,
  output logic [LVL_W-1:0] fifo_level
);
  uart_state_t                state;
  logic [BAUD_W-1:0]          baud;
  logic [2:0]                 bit_idx;
  logic [UART_DATA_BITS-1:0]  shift;
  logic [7:0]                 fifo_rdata;
  logic                       fifo_full, fifo_empty;
  logic                       baud_end, pop;
`ifdef UART_TX_PARITY_EN
  logic                       parity_bit;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  // Pop from IDLE, or at the last stop-bit cycle so frames run back to back.
  assign pop  = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));
  assign busy = (state != IDLE) || (fifo_level != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (tx_valid && fifo_full) overflow <= 1'b1;
  end

  // tx_out is registered and loaded with the level of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_out  <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (pop) begin
      state   <= START;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= fifo_rdata;
      tx_out  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^fifo_rdata;
`endif
    end else begin
      case (state)
        IDLE: tx_out <= UART_IDLE_LEVEL;
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_out  <= shift[0];
          end else baud <= baud + BAUD_W'(1);
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity_bit;
`else
              state  <= STOP;
              tx_out <= UART_IDLE_LEVEL;
`endif
            end else begin
              shift   <= {1'b0, shift[UART_DATA_BITS-1:1]};
              bit_idx <= bit_idx + 3'(1);
              tx_out  <= shift[1];   // next bit after the shift
            end
          end else baud <= baud + BAUD_W'(1);
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud   <= '0;
            state  <= STOP;
            tx_out <= UART_IDLE_LEVEL;
          end else baud <= baud + BAUD_W'(1);
        end
`endif
        STOP: begin
          // A pending byte is handled by the pop branch above.
          if (baud_end) begin
            baud   <= '0;
            state  <= IDLE;
            tx_out <= UART_IDLE_LEVEL;
          end else baud <= baud + BAUD_W'(1);
        end
        default: begin
          state  <= IDLE;
          baud   <= '0;
          tx_out <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end
endmodule
